fetcher: RTL
============

Name: fetcher

Overview:
- Instruction fetch stage: the producer side of the decoder interface.
- Keeps the architectural fetch PC and issues one word-aligned read per `enabled` pulse on a ready/valid instruction-memory port.
- Delivers `pc`/`instr_raw` with a one-cycle `completed` pulse; the decoder consumes them on that pulse.
- Accepts a jump redirect from the execute/branch logic.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'h00000013, value driven on instr_raw when no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
enabled  input  1  single-cycle start-fetch pulse from pipeline control
jump_en  input  1  sampled with enabled; fetch from jump_pc instead of sequential PC
jump_pc  input  32  redirect target
imem_req  output  1  read request, registered, held until accepted
imem_addr  output  32  read address, stable while imem_req=1
imem_ready  input  1  memory accepts request when imem_req&imem_ready
imem_valid  input  1  read data valid, one cycle, at most one per accepted request
imem_rdata  input  32  read data
completed  output  1  one-cycle pulse: pc/instr_raw valid
pc  output  32  address of delivered instruction
instr_raw  output  32  delivered instruction word
misaligned  output  1  valid with completed: target[1:0]!=0, no memory access made

Behaviour:
- Reset (async, rstn=0), all registered:
  - state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, instr_raw=NOP_INSTR.
  - imem_req=0, imem_addr=RESET_PC, completed=0, misaligned=0.
  - Reset mid-transaction abandons it. A late imem_valid after reset release is ignored while in IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, on enabled=1:
  - target = jump_en ? jump_pc : fetch_pc.
  - If target[1:0]!=0: go to DONE with pc=target, instr_raw=NOP_INSTR, misaligned=1; fetch_pc unchanged; no request issued.
  - Otherwise: imem_req<=1, imem_addr<=target, go to REQ.
- REQ:
  - Hold imem_req/imem_addr until imem_ready=1; then drop imem_req the next cycle.
  - If imem_valid=1 in the same cycle as acceptance (zero-latency memory): capture and go to DONE.
  - Otherwise go to WAIT.
- WAIT, on imem_valid=1:
  - instr_raw<=imem_rdata, pc<=imem_addr, misaligned<=0.
  - fetch_pc<=imem_addr+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
  - Go to DONE.
- DONE: completed=1 for exactly this cycle, then IDLE.
- pc/instr_raw/misaligned hold their values until the next capture.
- Minimum latency: enabled at cycle N → imem_req high at N+1 → completed at N+2 (zero-latency memory), else N+3+wait cycles.
- enabled while not IDLE (REQ/WAIT/DONE) is ignored: no queuing, no error. jump_en/jump_pc are only sampled with an accepted enabled.
- imem_valid in IDLE/DONE, or in REQ before acceptance, is ignored.
- Misaligned fetch: completed is still pulsed (latency N+1 → DONE at N+1, completed at N+1) so control can trap.
- Only one request is outstanding at any time.

Decomposition:
- Shared package (def.sv): fetch_state_t enum {IDLE,REQ,WAIT,DONE}; NOP encoding constant; INSTR_BYTES=4 constant.
- No sub-module. The single FSM plus PC register is the natural granularity.
- The next-PC adder stays inline.

Test Plan:
- Reset, then enabled with jump_en=0; memory ready=1 and valid with rdata=32'h00500093 one cycle after acceptance → imem_addr=0; completed pulses once; pc=0, instr_raw=32'h00500093; then second enabled → imem_addr=4.
- Redirect: enabled with jump_en=1, jump_pc=32'h00000100 → imem_addr=32'h100; after completion, next sequential fetch addr=32'h104.
- Stall: imem_ready low 3 cycles, then valid 2 cycles after acceptance → imem_req/imem_addr stable throughout; completed exactly once; extra enabled pulses during stall cause no second request.
- Misaligned: enabled, jump_en=1, jump_pc=32'h00000102 → imem_req never asserts; completed=1 with misaligned=1, pc=32'h102, instr_raw=32'h00000013.
- Wrap and zero-latency: jump to 32'hFFFFFFFC with ready&valid same cycle → completed at N+2; next sequential imem_addr=0.
- Async reset asserted in WAIT → outputs immediately at reset values; stray imem_valid after release gives no completed; next enabled fetches RESET_PC.

Source files
------------

// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and
// instruction encoding constants.
package fetcher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } fetch_state_t;

  localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

endpackage

// File: rtl/fetcher_if.sv
// Ready/valid instruction-memory read port between the fetch stage (master)
// and instruction memory (slave).
interface fetcher_if;

  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  valid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output valid,
    output rdata
  );

endinterface

// File: rtl/fetcher.sv
// Instruction fetch stage: owns the fetch PC, issues one word-aligned read per
// enabled pulse and hands pc/instr_raw to the decoder with a completed pulse.
module fetcher
  import fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enabled,
  input  logic             jump_en,
  input  logic [31:0]      jump_pc,
  fetcher_if.master        imem,
  output logic             completed,
  output logic [31:0]      pc,
  output logic [31:0]      instr_raw,
  output logic             misaligned
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic         completed_q, completed_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         mis_q, mis_d;
  logic [31:0]  target;
  logic         capture;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      completed_q <= 1'b0;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      completed_q <= completed_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      mis_q       <= mis_d;
    end
  end

  // Memory data is only taken after the request has been accepted, so a
  // valid arriving in IDLE/DONE or before acceptance never reaches the decoder.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    mis_d      = mis_q;
    target     = jump_en ? jump_pc : fetch_pc_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enabled) begin
          if (target[1:0] != 2'b00) begin
            state_d = DONE;
            pc_d    = target;
            instr_d = NOP_INSTR;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = target;
          end
        end
      end
      REQ: begin
        if (imem.ready) begin
          req_d = 1'b0;
          if (imem.valid) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem.valid) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Sequential PC advances modulo 2^32, so the last word wraps to zero.
    if (capture) begin
      pc_d       = addr_q;
      instr_d    = imem.rdata;
      mis_d      = 1'b0;
      fetch_pc_d = addr_q + INSTR_BYTES;
    end

    completed_d = (state_d == DONE);
  end

  assign imem.req   = req_q;
  assign imem.addr  = addr_q;
  assign completed  = completed_q;
  assign pc         = pc_q;
  assign instr_raw  = instr_q;
  assign misaligned = mis_q;

endmodule
